// File: rtl/weight_sink_pkg.sv
// weight_sink_pkg
//   Shared definitions for the weight stream sink: the load-state encoding
//   and a pointer-width helper that stays legal for a one-word tensor.
package weight_sink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } sink_state_t;

    // Width of a word pointer into a RAM of 'depth' words (never zero).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/weight_sink_ram.sv
// weight_sink_ram
//   Simple dual-port weight store: DEPTH words of WIDTH bits.
//   Ports:
//     clk, rst      - clock; asynchronous active-low reset (read stages only)
//     we/waddr/wdata- synchronous write port
//     address0, ce0 - ROM-style read request; ce0 gates both read stages
//     q0            - read data, two enabled edges after address0 is sampled
//   Memory contents are never reset. A read and a write to the same word in
//   one cycle return the old word.
module weight_sink_ram
    import weight_sink_pkg::*;
#(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned PTR_W      = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic                  ce0,
    output logic [WIDTH-1:0]      q0
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_stage1;
    logic [WIDTH-1:0] rd_word;
    logic [PTR_W-1:0] rd_idx;
    logic             in_range;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range addresses read as zero; the value is don't-care to the
    // consumer, this just keeps the array access bounded.
    always_comb begin
        in_range = (32'(address0) < DEPTH);
        rd_idx   = address0[PTR_W-1:0];
        rd_word  = in_range ? mem[rd_idx] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_stage1 <= '0;
            q0        <= '0;
        end else if (ce0) begin
            rd_stage1 <= rd_word;
            q0        <= rd_stage1;
        end
    end

endmodule

// File: rtl/weight_stream_sink.sv
// weight_stream_sink
//   Receives a weight tensor as valid/ready beats, stores one beat per RAM
//   word and, once complete, serves it through a 2-cycle ROM-style port.
//   Ports:
//     clk            - rising-edge clock
//     rst            - asynchronous active-low reset
//     data_in        - beat, element j at bits [P*j+P-1 : P*j]
//     data_in_valid  - beat valid
//     data_in_ready  - high only while filling (state-only)
//     start          - pulse: begin or restart a load (wins over clear)
//     clear          - pulse: drop the loaded tensor
//     full           - complete tensor held
//     address0/ce0/q0- read port, q0 two enabled edges after address0
module weight_stream_sink
    import weight_sink_pkg::*;
#(
    parameter int unsigned WEIGHT_TENSOR_SIZE_DIM_0 = 32,
    parameter int unsigned WEIGHT_TENSOR_SIZE_DIM_1 = 1,
    parameter int unsigned WEIGHT_PRECISION_0       = 16,
    parameter int unsigned WEIGHT_PRECISION_1       = 3,
    parameter int unsigned WEIGHT_PARALLELISM_DIM_0 = 1,
    parameter int unsigned WEIGHT_PARALLELISM_DIM_1 = 1,
    parameter int unsigned IN_DEPTH =
        (WEIGHT_TENSOR_SIZE_DIM_0 * WEIGHT_TENSOR_SIZE_DIM_1) /
        (WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1),
    parameter int unsigned ADDR_WIDTH = $clog2(IN_DEPTH) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1-1:0] data_in,
    input  logic data_in_valid,
    output logic data_in_ready,
    input  logic start,
    input  logic clear,
    output logic full,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic ce0,
    output logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1-1:0] q0
);

    localparam int unsigned PAR    = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
    localparam int unsigned WORD_W = WEIGHT_PRECISION_0 * PAR;
    localparam int unsigned PTR_W  = ptr_width(IN_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(IN_DEPTH - 1);

    // The fraction width is metadata for the consumer only; a format whose
    // fraction exceeds its width shows up as this block in the hierarchy.
    if (WEIGHT_PRECISION_1 > WEIGHT_PRECISION_0) begin : g_frac_exceeds_width
    end

    sink_state_t      state, state_n;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
    logic             wr_en;
    logic [WORD_W-1:0] packed_beat;

    // Element j already sits at bits [P*j+P-1 : P*j], which is the word layout.
    assign packed_beat = data_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
        end else begin
            state  <= state_n;
            wr_ptr <= wr_ptr_n;
        end
    end

    // start is checked first in every state so it wins over clear and also
    // suppresses the write of a beat handshaked in the same cycle.
    always_comb begin
        state_n       = state;
        wr_ptr_n      = wr_ptr;
        wr_en         = 1'b0;
        data_in_ready = 1'b0;
        full          = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n  = FILL;
                    wr_ptr_n = '0;
                end
            end
            FILL: begin
                data_in_ready = 1'b1;
                if (start) begin
                    wr_ptr_n = '0;
                end else if (clear) begin
                    state_n  = IDLE;
                    wr_ptr_n = '0;
                end else if (data_in_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_PTR) begin
                        state_n  = FULL;
                        wr_ptr_n = '0;
                    end else begin
                        wr_ptr_n = wr_ptr + 1'b1;
                    end
                end
            end
            FULL: begin
                full = 1'b1;
                if (start) begin
                    state_n  = FILL;
                    wr_ptr_n = '0;
                end else if (clear) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n  = IDLE;
                wr_ptr_n = '0;
            end
        endcase
    end

    weight_sink_ram #(
        .DEPTH      (IN_DEPTH),
        .WIDTH      (WORD_W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PTR_W      (PTR_W)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en),
        .waddr    (wr_ptr),
        .wdata    (packed_beat),
        .address0 (address0),
        .ce0      (ce0),
        .q0       (q0)
    );

endmodule

// File: tb/tb_weight_stream_sink.sv
module tb_weight_stream_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: defaults (IN_DEPTH=32, 16-bit words, 6-bit address)
    logic        a_rst, a_valid, a_ready, a_start, a_clear, a_full, a_ce;
    logic [15:0] a_data, a_q;
    logic [5:0]  a_addr;

    // Instance B: DIM_0=16, PAR_0=4 (IN_DEPTH=4, 64-bit words, 3-bit address)
    logic        b_rst, b_valid, b_ready, b_start, b_clear, b_full, b_ce;
    logic [63:0] b_data, b_q;
    logic [2:0]  b_addr;

    weight_stream_sink dut_a (
        .clk(clk), .rst(a_rst), .data_in(a_data), .data_in_valid(a_valid),
        .data_in_ready(a_ready), .start(a_start), .clear(a_clear), .full(a_full),
        .address0(a_addr), .ce0(a_ce), .q0(a_q)
    );

    weight_stream_sink #(
        .WEIGHT_TENSOR_SIZE_DIM_0 (16),
        .WEIGHT_PARALLELISM_DIM_0 (4)
    ) dut_b (
        .clk(clk), .rst(b_rst), .data_in(b_data), .data_in_valid(b_valid),
        .data_in_ready(b_ready), .start(b_start), .clear(b_clear), .full(b_full),
        .address0(b_addr), .ce0(b_ce), .q0(b_q)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input string tag, input logic [5:0] addr, input logic [15:0] exp);
        a_addr = addr;
        a_ce   = 1'b1;
        tick();
        tick();
        check(tag, 64'(a_q), 64'(exp));
    endtask

    task automatic load_a(input logic [15:0] base);
        a_start = 1'b1;
        a_valid = 1'b0;
        tick();
        a_start = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a_data = base + 16'(i);
            tick();
        end
        a_valid = 1'b0;
    endtask

    int cyc;
    int acc;

    initial begin
        a_rst = 1'b0; a_valid = 1'b0; a_start = 1'b0; a_clear = 1'b0;
        a_ce = 1'b0; a_data = '0; a_addr = '0;
        b_rst = 1'b0; b_valid = 1'b0; b_start = 1'b0; b_clear = 1'b0;
        b_ce = 1'b0; b_data = '0; b_addr = '0;

        tick();
        tick();
        check("rst_full",  64'(a_full),  64'd0);
        check("rst_ready", 64'(a_ready), 64'd0);
        check("rst_q0",    64'(a_q),     64'd0);
        a_rst = 1'b1;
        b_rst = 1'b1;

        // Valid held high without start: never ready
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready", 64'(a_ready), 64'd0);
        end
        a_valid = 1'b0;

        // Continuous load 0x0000..0x001F, measuring start-to-full latency
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_valid = 1'b1;
        check("first_ready", 64'(a_ready), 64'd1);
        cyc = 0;
        while (!a_full && cyc < 100) begin
            a_data = 16'(cyc);
            tick();
            cyc++;
        end
        a_valid = 1'b0;
        check("full_cycle", 64'(cyc + 1), 64'd33);
        check("full_ready_low", 64'(a_ready), 64'd0);
        read_a("rd5",  6'd5,  16'h0005);
        read_a("rd31", 6'd31, 16'h001F);

        // Abort after 10 beats; the beat in the start cycle is discarded
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_data = 16'hA000 + 16'(i);
            tick();
        end
        a_start = 1'b1;
        a_data  = 16'hBEEF;
        tick();
        a_start = 1'b0;
        check("abort_ready", 64'(a_ready), 64'd1);
        check("abort_full",  64'(a_full),  64'd0);
        for (int i = 0; i < 32; i++) begin
            a_data = 16'h1000 + 16'(i);
            tick();
        end
        a_valid = 1'b0;
        check("abort_reload_full", 64'(a_full), 64'd1);
        read_a("abort_rd0",  6'd0,  16'h1000);
        read_a("abort_rd9",  6'd9,  16'h1009);
        read_a("abort_rd10", 6'd10, 16'h100A);

        // clear+start together from FULL: start wins
        a_clear = 1'b1;
        a_start = 1'b1;
        tick();
        a_clear = 1'b0;
        a_start = 1'b0;
        check("cs_ready", 64'(a_ready), 64'd1);
        check("cs_full",  64'(a_full),  64'd0);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check("clr_fill_ready", 64'(a_ready), 64'd0);
        read_a("clr_rd3", 6'd3, 16'h1003);

        // clear alone from FULL
        load_a(16'h1000);
        check("reload_full", 64'(a_full), 64'd1);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check("clr_full",  64'(a_full),  64'd0);
        check("clr_ready", 64'(a_ready), 64'd0);
        read_a("clr_rd7",  6'd7,  16'h1007);
        read_a("clr_rd20", 6'd20, 16'h1014);

        // Random valid: exactly 32 beats accepted, full only after the last
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 32 && cyc < 1000) begin
            a_valid = 1'($urandom_range(0, 1));
            a_data  = 16'(acc);
            if (a_valid && a_ready) acc++;
            tick();
            cyc++;
            if (acc < 32) check("rand_early_full", 64'(a_full), 64'd0);
        end
        a_valid = 1'b0;
        check("rand_accepted", 64'(acc), 64'd32);
        check("rand_full", 64'(a_full), 64'd1);
        for (int i = 0; i < 32; i++) begin
            read_a("rand_image", 6'(i), 16'(i));
        end

        // Instance B: packed beats of four elements
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1;
        b_data = 64'h0004_0003_0002_0001; tick();
        b_data = 64'h0008_0007_0006_0005; tick();
        b_data = 64'h1111_2222_3333_4444; tick();
        b_data = 64'hAAAA_BBBB_CCCC_DDDD; tick();
        b_valid = 1'b0;
        check("b_full", 64'(b_full), 64'd1);
        b_addr = 3'd0;
        b_ce   = 1'b1;
        tick();
        tick();
        check("b_rd0", b_q, 64'h0004_0003_0002_0001);
        b_addr = 3'd1;
        b_ce   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_ce_freeze", b_q, 64'h0004_0003_0002_0001);
        end
        b_ce = 1'b1;
        tick();
        tick();
        check("b_rd1", b_q, 64'h0008_0007_0006_0005);

        // Reset asserted mid-FILL
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1;
        b_data  = 64'h5;
        tick();
        tick();
        check("b_fill_ready", 64'(b_ready), 64'd1);
        #2;
        b_rst = 1'b0;
        #1;
        check("b_rst_ready", 64'(b_ready), 64'd0);
        check("b_rst_full",  64'(b_full),  64'd0);
        check("b_rst_q0",    b_q,          64'd0);
        tick();
        b_rst = 1'b1;
        tick();
        check("b_post_rst_ready", 64'(b_ready), 64'd0);
        b_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
